// File: rtl/h_bdy_arb_if.sv
// Hash-table body command/response types and the bus bundle between the
// requesters, the arbiter and the hash-table body.
package h_pkg;
  typedef logic [1:0]  opcode_t;
  typedef logic [15:0] k_t;
  typedef logic [31:0] v_t;
  typedef logic [1:0]  status_t;
endpackage

interface h_bdy_arb_if #(
  parameter int N     = 4,
  parameter int DEPTH = 8
);
  logic             [N-1:0] i_req_vld_w;
  h_pkg::opcode_t   [N-1:0] i_req_opcode_w;
  h_pkg::k_t        [N-1:0] i_req_k_w;
  h_pkg::v_t        [N-1:0] i_req_v_w;
  logic             [N-1:0] o_req_rdy_w;
  logic                     o_cmd_vld_w;
  h_pkg::opcode_t           o_cmd_opcode_w;
  h_pkg::k_t                o_cmd_k_w;
  h_pkg::v_t                o_cmd_v_w;
  logic                     i_cmd_rdy_w;
  logic                     i_rsp_vld;
  h_pkg::status_t           i_rsp_status;
  h_pkg::v_t                i_rsp_v;
  logic             [N-1:0] o_rsp_vld_r;
  h_pkg::status_t           o_rsp_status_r;
  h_pkg::v_t                o_rsp_v_r;
  logic [$clog2(DEPTH+1)-1:0] o_outstanding_r;
  logic                     o_err_r;

  // Arbiter side
  modport slave (
    input  i_req_vld_w, i_req_opcode_w, i_req_k_w, i_req_v_w,
    input  i_cmd_rdy_w, i_rsp_vld, i_rsp_status, i_rsp_v,
    output o_req_rdy_w, o_cmd_vld_w, o_cmd_opcode_w, o_cmd_k_w, o_cmd_v_w,
    output o_rsp_vld_r, o_rsp_status_r, o_rsp_v_r, o_outstanding_r, o_err_r
  );

  // Environment side (requesters plus body)
  modport master (
    output i_req_vld_w, i_req_opcode_w, i_req_k_w, i_req_v_w,
    output i_cmd_rdy_w, i_rsp_vld, i_rsp_status, i_rsp_v,
    input  o_req_rdy_w, o_cmd_vld_w, o_cmd_opcode_w, o_cmd_k_w, o_cmd_v_w,
    input  o_rsp_vld_r, o_rsp_status_r, o_rsp_v_r, o_outstanding_r, o_err_r
  );
endinterface

// File: rtl/h_bdy_arb.sv
// Round-robin arbiter sharing the hash-table body command port between N
// requesters. Accepted requester IDs are queued in order so each in-order
// body response is routed back to the requester that issued the command.
module h_bdy_arb #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         arst,
  h_bdy_arb_if.slave  bus
);
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IW-1:0]  ptr;
  logic [IW-1:0]  fifo [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  outstanding;
  logic [N-1:0]   rsp_vld_r;
  h_pkg::status_t rsp_status_r;
  h_pkg::v_t      rsp_v_r;
  logic           err_r;

  logic           any;
  logic [IW-1:0]  g;
  int             j;
  logic           full;
  logic           empty;
  logic           cmd_vld;
  logic           fire;
  logic           pop;
  h_pkg::opcode_t cmd_op;
  h_pkg::k_t      cmd_k;
  h_pkg::v_t      cmd_v;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] id);
    logic [N-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  // Occupancy flags come from start-of-cycle state, so a same-cycle pop
  // never opens room for a push.
  assign full    = (outstanding == CW'(DEPTH));
  assign empty   = (outstanding == '0);
  assign cmd_vld = any & ~full;
  assign fire    = cmd_vld & bus.i_cmd_rdy_w;
  assign pop     = bus.i_rsp_vld & ~empty;

  // Grant: first valid requester at or above ptr, wrapping modulo N
  always_comb begin
    any = 1'b0;
    g   = '0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && bus.i_req_vld_w[j]) begin
        any = 1'b1;
        g   = IW'(j);
      end
    end
  end

  // Command mux: fields follow the grant, zero when nobody is requesting
  always_comb begin
    cmd_op = '0;
    cmd_k  = '0;
    cmd_v  = '0;
    if (any) begin
      cmd_op = bus.i_req_opcode_w[g];
      cmd_k  = bus.i_req_k_w[g];
      cmd_v  = bus.i_req_v_w[g];
    end
  end

  assign bus.o_cmd_vld_w    = cmd_vld;
  assign bus.o_cmd_opcode_w = cmd_op;
  assign bus.o_cmd_k_w      = cmd_k;
  assign bus.o_cmd_v_w      = cmd_v;
  assign bus.o_req_rdy_w    = fire ? onehot(g) : '0;

  // Round-robin pointer advances past the winner only on an accepted issue
  always_ff @(posedge clk or posedge arst) begin
    if (arst)      ptr <= '0;
    else if (fire) ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
  end

  // ID FIFO storage; contents are meaningless until the pointers cover them
  always_ff @(posedge clk) begin
    if (fire) fifo[wr_ptr] <= g;
  end

  // FIFO pointers and outstanding count; pointers wrap naturally
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      outstanding <= outstanding + CW'(fire) - CW'(pop);
    end
  end

  // Response routing: one-hot valid for one cycle, data held between pops
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rsp_vld_r    <= '0;
      rsp_status_r <= '0;
      rsp_v_r      <= '0;
    end else begin
      rsp_vld_r <= pop ? onehot(fifo[rd_ptr]) : '0;
      if (pop) begin
        rsp_status_r <= bus.i_rsp_status;
        rsp_v_r      <= bus.i_rsp_v;
      end
    end
  end

  // Sticky error: a response with nothing outstanding is dropped and flagged
  always_ff @(posedge clk or posedge arst) begin
    if (arst)                     err_r <= 1'b0;
    else if (bus.i_rsp_vld & empty) err_r <= 1'b1;
  end

  assign bus.o_rsp_vld_r     = rsp_vld_r;
  assign bus.o_rsp_status_r  = rsp_status_r;
  assign bus.o_rsp_v_r       = rsp_v_r;
  assign bus.o_outstanding_r = outstanding;
  assign bus.o_err_r         = err_r;
endmodule

// File: tb/tb_h_bdy_arb.sv
// Bench for h_bdy_arb: table of hand-derived vectors plus corner sequences,
// with a reference model and a response scoreboard checking every cycle.
module tb_h_bdy_arb;
  import h_pkg::*;
  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  h_bdy_arb_if #(.N(N), .DEPTH(DEPTH)) bus();
  h_bdy_arb #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .arst(arst), .bus(bus));

  typedef struct {
    int      id;
    status_t st;
    v_t      v;
  } rsp_t;

  typedef struct {
    logic [N-1:0] vld;
    logic         rdy;
    logic         rsp;
    logic         exp_cmd_vld;
    logic [N-1:0] exp_req_rdy;
    logic [N-1:0] exp_rsp_oh;
    logic [3:0]   exp_out;
  } vec_t;

  int      checks   = 0;
  int      failures = 0;
  int      mptr     = 0;
  int      mq[$];
  rsp_t    exp_q[$];
  logic    merr     = 1'b0;
  status_t last_st  = '0;
  v_t      last_v   = '0;

  logic         obs_cmd_vld;
  logic [N-1:0] obs_rdy;
  logic [N-1:0] obs_rsp;
  logic [3:0]   obs_out;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, entered and left at posedge+1
  task automatic cycle(input logic [N-1:0] vld, input logic rdy, input logic rsp);
    int      g;
    int      j;
    logic    any;
    logic    full;
    logic    fire;
    rsp_t    r;
    status_t st;
    v_t      v;
    st = status_t'($urandom_range(0, 3));
    v  = $urandom;
    bus.i_req_vld_w  = vld;
    bus.i_cmd_rdy_w  = rdy;
    bus.i_rsp_vld    = rsp;
    bus.i_rsp_status = st;
    bus.i_rsp_v      = v;
    #1;
    any = 1'b0;
    g   = 0;
    for (int i = 0; i < N; i++) begin
      j = (mptr + i) % N;
      if (!any && vld[j]) begin
        any = 1'b1;
        g   = j;
      end
    end
    full = (mq.size() == DEPTH);
    fire = any && !full && rdy;
    obs_cmd_vld = bus.o_cmd_vld_w;
    obs_rdy     = bus.o_req_rdy_w;
    chk("cmd_vld", bus.o_cmd_vld_w, any && !full);
    chk("req_rdy", bus.o_req_rdy_w, fire ? (64'd1 << g) : 64'd0);
    if (any) begin
      chk("cmd_k",  bus.o_cmd_k_w,      64'hA000 + g);
      chk("cmd_op", bus.o_cmd_opcode_w, g % 4);
      chk("cmd_v",  bus.o_cmd_v_w,      64'hC0DE0000 + g);
    end else begin
      chk("cmd_k_idle", bus.o_cmd_k_w, 64'd0);
    end
    if (rsp && mq.size() == 0) merr = 1'b1;
    if (rsp && mq.size() > 0) begin
      r.id = mq.pop_front();
      r.st = st;
      r.v  = v;
      exp_q.push_back(r);
    end
    if (fire) begin
      mq.push_back(g);
      mptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
    obs_rsp = bus.o_rsp_vld_r;
    obs_out = 4'(bus.o_outstanding_r);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("rsp_vld", bus.o_rsp_vld_r, 64'd1 << r.id);
      last_st = r.st;
      last_v  = r.v;
    end else begin
      chk("rsp_vld_idle", bus.o_rsp_vld_r, 64'd0);
    end
    chk("rsp_status",  bus.o_rsp_status_r,  last_st);
    chk("rsp_v",       bus.o_rsp_v_r,       last_v);
    chk("outstanding", bus.o_outstanding_r, mq.size());
    chk("err",         bus.o_err_r,         merr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_vld"}, bus.o_cmd_vld_w, 64'd0);
    chk({tag, "_req_rdy"}, bus.o_req_rdy_w, 64'd0);
    chk({tag, "_cmd_k"},   bus.o_cmd_k_w, 64'd0);
    chk({tag, "_rsp_vld"}, bus.o_rsp_vld_r, 64'd0);
    chk({tag, "_status"},  bus.o_rsp_status_r, 64'd0);
    chk({tag, "_v"},       bus.o_rsp_v_r, 64'd0);
    chk({tag, "_out"},     bus.o_outstanding_r, 64'd0);
    chk({tag, "_err"},     bus.o_err_r, 64'd0);
  endtask

  task automatic model_reset();
    mptr = 0;
    mq.delete();
    exp_q.delete();
    merr    = 1'b0;
    last_st = '0;
    last_v  = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      bus.i_req_opcode_w[i] = opcode_t'(i % 4);
      bus.i_req_k_w[i]      = k_t'(16'hA000 + i);
      bus.i_req_v_w[i]      = v_t'(32'hC0DE0000 + i);
    end
    bus.i_req_vld_w  = '0;
    bus.i_cmd_rdy_w  = 1'b0;
    bus.i_rsp_vld    = 1'b0;
    bus.i_rsp_status = '0;
    bus.i_rsp_v      = '0;

    //            vld    rdy   rsp   cmdv  req_rdy rsp_oh out
    tbl[0]  = '{4'hF, 1'b1, 1'b0, 1'b1, 4'h1, 4'h0, 4'd1};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'h2, 4'h1, 4'd1};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'h4, 4'h2, 4'd1};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'h8, 4'h4, 4'd1};
    tbl[4]  = '{4'hF, 1'b1, 1'b1, 1'b1, 4'h1, 4'h8, 4'd1};
    tbl[5]  = '{4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'd0};
    tbl[6]  = '{4'h4, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'd0};
    tbl[7]  = '{4'h4, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'd0};
    tbl[8]  = '{4'h4, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'd0};
    tbl[9]  = '{4'h4, 1'b1, 1'b0, 1'b1, 4'h4, 4'h0, 4'd1};
    tbl[10] = '{4'hF, 1'b1, 1'b1, 1'b1, 4'h8, 4'h4, 4'd1};
    tbl[11] = '{4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h8, 4'd0};

    #2;
    chk_reset_vals("por");
    @(posedge clk);
    #1;
    arst = 1'b0;

    // Table: rotation through all requesters, then stalled single requester
    for (int t = 0; t < 12; t++) begin
      cycle(tbl[t].vld, tbl[t].rdy, tbl[t].rsp);
      chk($sformatf("tbl%0d_cmd_vld", t), obs_cmd_vld, tbl[t].exp_cmd_vld);
      chk($sformatf("tbl%0d_req_rdy", t), obs_rdy, tbl[t].exp_req_rdy);
      chk($sformatf("tbl%0d_rsp_oh", t), obs_rsp, tbl[t].exp_rsp_oh);
      chk($sformatf("tbl%0d_out", t), obs_out, tbl[t].exp_out);
    end

    // Fill the ID FIFO, then pop-without-push at full, push on the next cycle
    for (int i = 0; i < DEPTH; i++) cycle(4'hF, 1'b1, 1'b0);
    chk("fill_out", obs_out, 4'd8);
    cycle(4'hF, 1'b1, 1'b0);
    chk("full_cmd_vld", obs_cmd_vld, 1'b0);
    cycle(4'hF, 1'b1, 1'b1);
    chk("full_pop_rdy", obs_rdy, 4'h0);
    chk("full_pop_out", obs_out, 4'd7);
    cycle(4'hF, 1'b1, 1'b0);
    chk("refill_out", obs_out, 4'd8);

    // Drain to 3, then simultaneous push and pop
    for (int i = 0; i < 5; i++) cycle(4'h0, 1'b0, 1'b1);
    chk("drain3_out", obs_out, 4'd3);
    cycle(4'hF, 1'b1, 1'b1);
    chk("pushpop_out", obs_out, 4'd3);
    chk("pushpop_rsp_nz", (obs_rsp != 0), 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'h0, 1'b0, 1'b1);
    chk("drained_out", obs_out, 4'd0);

    // Response with nothing outstanding: sticky error, no routed response
    cycle(4'h0, 1'b0, 1'b1);
    chk("err_set", bus.o_err_r, 1'b1);
    chk("err_rsp", obs_rsp, 4'h0);
    cycle(4'h0, 1'b0, 1'b0);
    chk("err_sticky", bus.o_err_r, 1'b1);

    // Asynchronous reset with five commands outstanding
    for (int i = 0; i < 5; i++) cycle(4'hF, 1'b1, 1'b0);
    chk("pre_rst_out", obs_out, 4'd5);
    bus.i_req_vld_w = '0;
    bus.i_cmd_rdy_w = 1'b0;
    bus.i_rsp_vld   = 1'b0;
    #2;
    arst = 1'b1;
    #1;
    chk_reset_vals("mid");
    @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();

    // First push after reset with a same-cycle response: error, ID kept
    cycle(4'hF, 1'b1, 1'b1);
    chk("post_rst_grant", obs_rdy, 4'h1);
    chk("post_rst_err", bus.o_err_r, 1'b1);
    chk("post_rst_out", obs_out, 4'd1);
    cycle(4'h0, 1'b0, 1'b1);
    chk("post_rst_rsp", obs_rsp, 4'h1);
    cycle(4'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
